// File: rtl/mdl_pgsrch_pkg.sv
// mdl_pgsrch_pkg: shared constants, step indices and FSM encoding
// for the bubble page-search sequencer.
package mdl_pgsrch_pkg;

   localparam int PAGE_MAX  = 2053;
   localparam int PGW       = 12;
   localparam int ROT_STEPS = 20;

   localparam logic [4:0] SERIAL_LAST = 5'd11;
   localparam logic [4:0] CMP_LATCH   = 5'd12;
   localparam logic [4:0] FRAME_END   = 5'd19;

   localparam logic [ROT_STEPS-1:0] ROT_RESET = 20'hFFFFE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      SEARCH = 2'd2
   } state_t;

   // absolute page successor, wrapping at the last position
   function automatic logic [PGW-1:0] abs_inc(input logic [PGW-1:0] v);
      return (v == PGW'(PAGE_MAX - 1)) ? '0 : v + PGW'(1);
   endfunction

endpackage

// File: rtl/mdl_rot20.sv
// mdl_rot20: 20-step one-cold frame rotator, step k drives bit k low.
// Advances once per clock enable, wraps step 19 -> step 0.
module mdl_rot20
   import mdl_pgsrch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   output logic [ROT_STEPS-1:0] rot_n
);

   // rotate the single low bit one place up per enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rot_n <= ROT_RESET;
      end else if (en) begin
         rot_n <= {rot_n[ROT_STEPS-2:0], rot_n[ROT_STEPS-1]};
      end
   end

endmodule

// File: rtl/mdl_pgsrch_ctrl.sv
// mdl_pgsrch_ctrl: page-search sequencer (frame timing, serializers, FSM).
// Optional macro MDL_PGSRCH_TIMEOUT_EN adds the PAGE_MAX-frame search timeout.
module mdl_pgsrch_ctrl
   import mdl_pgsrch_pkg::*;
(
   input  logic                 i_MCLK,
   input  logic                 i_RST,
   input  logic                 i_CLK2M_PCEN_n,
   input  logic                 i_REQ,
   input  logic [PGW-1:0]       i_PGNUM,
   input  logic                 i_ABORT,
   input  logic                 i_BUBROT,
   input  logic                 i_PGCMP_EQ,
   output logic [ROT_STEPS-1:0] o_ROT20_n,
   output logic                 o_PGREG_SR_LSB,
   output logic                 o_ABSPGCNTR_LSB,
   output logic                 o_BDI_EN,
   output logic                 o_UMODE_n,
   output logic                 o_BUSY,
   output logic                 o_HIT,
   output logic                 o_TIMEOUT,
   output logic [PGW-1:0]       o_ABSPG
);

   logic                 en;
   logic                 frame_end;
   logic                 ser_shift;
   logic                 ser_win;
   logic [ROT_STEPS-1:0] rot_n;
   state_t               state;
   state_t               state_nx;
   logic [PGW-1:0]       abs_cnt;
   logic [PGW-1:0]       abs_nx;
   logic [PGW-1:0]       pg_reg;
   logic [PGW-1:0]       pg_sr;
   logic [PGW-1:0]       abs_sr;
   logic                 frm_last;
   logic                 hit_evt;
   logic                 to_evt;
   logic                 hit;
   logic                 timeout;

   assign en = ~i_CLK2M_PCEN_n;

   mdl_rot20 u_rot (
      .clk   (i_MCLK),
      .rst   (i_RST),
      .en    (en),
      .rot_n (rot_n)
   );

   assign frame_end = ~rot_n[FRAME_END];
   assign ser_shift = ~&rot_n[SERIAL_LAST:0];
   assign ser_win   = ~&rot_n[CMP_LATCH-1:0];
   assign abs_nx    = i_BUBROT ? abs_inc(abs_cnt) : abs_cnt;

   // absolute page counter, advances once per frame while rotating
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         abs_cnt <= '0;
      end else if (en && frame_end) begin
         abs_cnt <= abs_nx;
      end
   end

   // relative page number, captured when a request is accepted
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         pg_reg <= '0;
      end else if (en && state == IDLE && i_REQ) begin
         pg_reg <= i_PGNUM;
      end
   end

   // serial shadows: reload at frame end so bit 0 leads the next frame
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         pg_sr  <= '0;
         abs_sr <= '0;
      end else if (en) begin
         if (frame_end) begin
            pg_sr  <= pg_reg;
            abs_sr <= abs_nx;
         end else if (ser_shift) begin
            pg_sr  <= pg_sr >> 1;
            abs_sr <= abs_sr >> 1;
         end
      end
   end

   assign o_PGREG_SR_LSB  = ser_win & pg_sr[0];
   assign o_ABSPGCNTR_LSB = ser_win & abs_sr[0];

`ifdef MDL_PGSRCH_TIMEOUT_EN
   logic [PGW-1:0] frm_cnt;

   assign frm_last = (frm_cnt == PGW'(PAGE_MAX - 1));

   // evaluated-frame counter, held clear outside of SEARCH
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         frm_cnt <= '0;
      end else if (en) begin
         if (state != SEARCH) begin
            frm_cnt <= '0;
         end else if (frame_end) begin
            frm_cnt <= frm_cnt + PGW'(1);
         end
      end
   end
`else
   assign frm_last = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         state <= IDLE;
      end else if (en) begin
         state <= state_nx;
      end
   end

   // FSM next state; abort beats a same-cycle hit, hit beats timeout
   always_comb begin
      state_nx = state;
      hit_evt  = 1'b0;
      to_evt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_REQ) state_nx = SYNC;
         end
         SYNC: begin
            if (i_ABORT) state_nx = IDLE;
            else if (frame_end) state_nx = SEARCH;
         end
         SEARCH: begin
            if (i_ABORT) begin
               state_nx = IDLE;
            end else if (frame_end) begin
               if (i_PGCMP_EQ) begin
                  hit_evt  = 1'b1;
                  state_nx = IDLE;
               end else if (frm_last) begin
                  to_evt   = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // result pulses last exactly one enable period
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         hit     <= 1'b0;
         timeout <= 1'b0;
      end else if (en) begin
         hit     <= hit_evt;
         timeout <= to_evt;
      end
   end

   // FSM outputs
   always_comb begin
      o_BUSY    = (state != IDLE);
      o_BDI_EN  = (state == SEARCH);
      o_UMODE_n = (state != SEARCH);
   end

   assign o_ROT20_n = rot_n;
   assign o_HIT     = hit;
   assign o_TIMEOUT = timeout;
   assign o_ABSPG   = abs_cnt;

endmodule

// File: tb/tb_mdl_pgsrch_ctrl.sv
// tb_mdl_pgsrch_ctrl: randomized and directed bench for mdl_pgsrch_ctrl
// against a frame-level behavioural model.
module tb_mdl_pgsrch_ctrl;

   localparam int PMAX = 2053;
`ifdef MDL_PGSRCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pcen_n = 1'b1;
   logic        req = 1'b0;
   logic [11:0] pgnum = '0;
   logic        abort = 1'b0;
   logic        bubrot = 1'b0;
   logic        eq = 1'b0;
   logic [19:0] rot_n;
   logic        ser_pg, ser_abs, bdi_en, umode_n, busy, hit, tmo;
   logic [11:0] abspg;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   mdl_pgsrch_ctrl dut (
      .i_MCLK          (clk),
      .i_RST           (rst),
      .i_CLK2M_PCEN_n  (pcen_n),
      .i_REQ           (req),
      .i_PGNUM         (pgnum),
      .i_ABORT         (abort),
      .i_BUBROT        (bubrot),
      .i_PGCMP_EQ      (eq),
      .o_ROT20_n       (rot_n),
      .o_PGREG_SR_LSB  (ser_pg),
      .o_ABSPGCNTR_LSB (ser_abs),
      .o_BDI_EN        (bdi_en),
      .o_UMODE_n       (umode_n),
      .o_BUSY          (busy),
      .o_HIT           (hit),
      .o_TIMEOUT       (tmo),
      .o_ABSPG         (abspg)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // behavioural model: enable index within frame, page numbers as ints
   int m_step = 0, m_abs = 0, m_pg = 0, m_frames = 0;
   int m_sh_abs = 0, m_sh_pg = 0;
   bit m_busy = 0, m_srch = 0, m_hit = 0, m_to = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_step = 0; m_abs = 0; m_pg = 0; m_frames = 0;
         m_sh_abs = 0; m_sh_pg = 0;
         m_busy = 0; m_srch = 0; m_hit = 0; m_to = 0;
      end else if (!pcen_n) begin
         bit fe;
         fe = (m_step == 19);
         m_hit = 0;
         m_to = 0;
         if (fe) begin
            if (bubrot) m_abs = (m_abs + 1) % PMAX;
            m_sh_abs = m_abs;
            m_sh_pg = m_pg;
         end
         if (!m_busy) begin
            if (req) begin
               m_busy = 1;
               m_pg = int'(pgnum);
            end
         end else if (abort) begin
            m_busy = 0;
            m_srch = 0;
         end else if (!m_srch) begin
            if (fe) begin
               m_srch = 1;
               m_frames = 0;
            end
         end else if (fe) begin
            m_frames++;
            if (eq) begin
               m_hit = 1; m_busy = 0; m_srch = 0;
            end else if (TO_EN && m_frames == PMAX) begin
               m_to = 1; m_busy = 0; m_srch = 0;
            end
         end
         m_step = (m_step + 1) % 20;
      end
   end

   // compare process: every output against the model, every cycle
   always @(negedge clk) begin
      if (chk_on) begin
         logic [19:0] er;
         for (int k = 0; k < 20; k++) er[k] = (k != m_step);
         check("rot20", rot_n, er);
         check("ser_pg", ser_pg,
               (m_step < 12) ? ((m_sh_pg >> m_step) & 1) : 0);
         check("ser_abs", ser_abs,
               (m_step < 12) ? ((m_sh_abs >> m_step) & 1) : 0);
         check("abspg", abspg, m_abs);
         check("busy", busy, m_busy);
         check("bdi_en", bdi_en, m_srch);
         check("umode_n", umode_n, !m_srch);
         check("hit", hit, m_hit);
         check("timeout", tmo, m_to);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int n, ffff_seen, hits, tos, bdi_cnt, wraps, prev_abs;
      logic [11:0] pg_seen;
      bit done;

      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      rst = 1'b0;
      check("reset_rot", rot_n, 20'hFFFFE);
      check("reset_abs", abspg, 0);
      check("reset_busy", busy, 0);

      // free-running rotator, counter frozen
      pcen_n = 1'b0;
      ffff_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (rot_n == 20'h7FFFF) ffff_seen++;
      end
      check("rot_step19_seen", ffff_seen, 2);
      check("rot_after40", rot_n, 20'hFFFFE);
      check("abs_frozen", abspg, 0);

      // hit on 5th search frame
      req = 1'b1;
      pgnum = 12'h0A5;
      tick();
      req = 1'b0;
      pgnum = 12'hF5A;
      n = 1; hits = 0; done = 0; pg_seen = '0;
      while (!done && n < 400) begin
         eq = m_srch && (m_frames == 4);
         if (m_srch && m_step < 12) pg_seen[m_step] = ser_pg;
         tick();
         n++;
         if (hit) begin
            hits++;
            done = 1;
         end
      end
      eq = 1'b0;
      check("hit_latency", n, 120);
      check("pg_serial", pg_seen, 12'h0A5);
      tick();
      check("hit_single", hit, 0);
      check("idle_after_hit", busy, 0);

      // abort at frame-3 end with EQ high
      req = 1'b1;
      tick();
      req = 1'b0;
      done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (m_srch && m_frames == 2 && m_step == 19) begin
            abort = 1'b1;
            eq = 1'b1;
            tick();
            abort = 1'b0;
            eq = 1'b0;
            check("abort_nohit", hit, 0);
            check("abort_idle", busy, 0);
            done = 1;
         end else begin
            tick();
         end
      end
      check("abort_reached", done, 1);

      // long search, EQ never set, counter rotating
      bubrot = 1'b1;
      req = 1'b1;
      tick();
      req = 1'b0;
      tos = 0; bdi_cnt = 0; wraps = 0; prev_abs = abspg;
      for (int i = 0; i < 60040; i++) begin
         tick();
         if (tmo) tos++;
         if (bdi_en) bdi_cnt++;
         if (prev_abs == 2052 && abspg == 0) wraps++;
         prev_abs = abspg;
      end
      check("abs_wrap", wraps, 1);
      if (TO_EN) begin
         check("timeout_once", tos, 1);
         check("timeout_frames", bdi_cnt, 41060);
      end else begin
         check("no_timeout", tos, 0);
         check("still_busy", busy, 1);
         abort = 1'b1;
         tick();
         abort = 1'b0;
      end

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         pcen_n = ($urandom_range(0, 3) == 0);
         req = ($urandom_range(0, 3) == 0);
         pgnum = 12'($urandom);
         abort = ($urandom_range(0, 63) == 0);
         bubrot = $urandom_range(0, 1);
         eq = ($urandom_range(0, 5) == 0);
         tick();
      end
      pcen_n = 1'b0; req = 1'b0; abort = 1'b0; eq = 1'b0;
      tick();

      // async reset mid-search at step 7
      bubrot = 1'b1;
      while (busy && n < 1000) begin
         abort = 1'b1;
         tick();
         n++;
      end
      abort = 1'b0;
      req = 1'b1;
      tick();
      req = 1'b0;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (m_srch && m_step == 7) done = 1;
         else tick();
      end
      check("reached_step7", done, 1);
      eq = 1'b1;
      #3 rst = 1'b1;
      #1;
      check("arst_rot", rot_n, 20'hFFFFE);
      check("arst_abs", abspg, 0);
      check("arst_busy", busy, 0);
      check("arst_hit", hit, 0);
      check("arst_to", tmo, 0);
      check("arst_umode", umode_n, 1);
      check("arst_bdi", bdi_en, 0);
      check("arst_ser", {ser_pg, ser_abs}, 0);
      @(negedge clk);
      rst = 1'b0;
      hits = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (hit || tmo) hits++;
      end
      check("arst_no_pulse", hits, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
